// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the ALU execution unit: opcodes, FSM states and default sizes.
package alu_exec_unit_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int MAX_SHIFT_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_LS  = 3'd4,
    OP_RS  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_LS) || (op == OP_RS);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bus of the ALU execution unit; master is the requester/consumer.
interface alu_exec_unit_if
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             err;

  modport master (
    output req_valid, opcode, in1, in2, rsp_ready,
    input  req_ready, rsp_valid, result, carry, zero, neg, err
  );

  modport slave (
    input  req_valid, opcode, in1, in2, rsp_ready,
    output req_ready, rsp_valid, result, carry, zero, neg, err
  );

endinterface

// File: rtl/alu_shift_seq.sv
// Iterative shifter: loads value/count/direction, shifts one bit per cycle, pulses done
// in the cycle after the final shift and keeps the last bit shifted out.
module alu_shift_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dir_left,
  input  logic [WIDTH-1:0] value_in,
  input  logic [CNT_W-1:0] count_in,
  output logic [WIDTH-1:0] value,
  output logic             last_bit,
  output logic             done
);

  logic [WIDTH-1:0] value_q;
  logic [CNT_W-1:0] count_q;
  logic             left_q;
  logic             last_q;
  logic             done_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      count_q <= '0;
      left_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (load) begin
      value_q <= value_in;
      count_q <= count_in;
      left_q  <= dir_left;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (count_q != '0) begin
      if (left_q) begin
        last_q  <= value_q[WIDTH-1];
        value_q <= {value_q[WIDTH-2:0], 1'b0};
      end else begin
        last_q  <= value_q[0];
        value_q <= {1'b0, value_q[WIDTH-1:1]};
      end
      count_q <= count_q - 1'b1;
      done_q  <= (count_q == CNT_W'(1));
    end else begin
      done_q  <= 1'b0;
    end
  end

  assign value    = value_q;
  assign last_bit = last_q;
  assign done     = done_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential ALU responder: one request at a time, single-cycle logic/arith, iterative
// shifts, registered result and flags held on the response handshake until consumed.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic             accept, load_shift, cap_exec, cap_shift;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] shift_value;
  logic             shift_last, shift_done;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] exec_result;
  logic             exec_carry, exec_err;

  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, neg_q, err_q;

  always_comb begin
    if (bus.in2 >= WIDTH'(MAX_SHIFT)) shift_cnt = CNT_W'(MAX_SHIFT);
    else                              shift_cnt = CNT_W'(bus.in2);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_shift = 1'b0;
    cap_exec   = 1'b0;
    cap_shift  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (is_shift(bus.opcode) && (shift_cnt != '0)) begin
            load_shift = 1'b1;
            state_d    = ST_SHIFT;
          end else begin
            state_d    = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        cap_exec = 1'b1;
        state_d  = ST_RESP;
      end
      ST_SHIFT: begin
        if (shift_done) begin
          cap_shift = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: operand latches carry no reset; they are always written on accept before use,
  // and only control state and visible outputs need a defined reset value.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= bus.opcode;
      a_q  <= bus.in1;
      b_q  <= bus.in2;
    end
  end

  alu_shift_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (load_shift),
    .dir_left (bus.opcode == OP_LS),
    .value_in (bus.in1),
    .count_in (shift_cnt),
    .value    (shift_value),
    .last_bit (shift_last),
    .done     (shift_done)
  );

  // Carry/borrow come from the extra top bit of the WIDTH+1 bit sum/difference.
  always_comb begin
    sum         = {1'b0, a_q} + {1'b0, b_q};
    diff        = {1'b0, a_q} - {1'b0, b_q};
    exec_result = '0;
    exec_carry  = 1'b0;
    exec_err    = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_result = sum[WIDTH-1:0];
        exec_carry  = sum[WIDTH];
      end
      OP_SUB: begin
        exec_result = diff[WIDTH-1:0];
        exec_carry  = diff[WIDTH];
      end
      OP_AND:       exec_result = a_q & b_q;
      OP_OR:        exec_result = a_q | b_q;
      OP_LS, OP_RS: exec_result = a_q;
      default:      exec_err    = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (cap_exec) begin
      result_q <= exec_result;
      carry_q  <= exec_carry;
      zero_q   <= (exec_result == '0);
      neg_q    <= exec_result[WIDTH-1];
      err_q    <= exec_err;
    end else if (cap_shift) begin
      result_q <= shift_value;
      carry_q  <= shift_last;
      zero_q   <= (shift_value == '0);
      neg_q    <= shift_value[WIDTH-1];
      err_q    <= 1'b0;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(8)) bus ();

  alu_exec_unit #(
    .WIDTH     (8),
    .MAX_SHIFT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 8-bit operands, shift count clamped to 8.
  function automatic void model(input logic [2:0] op, input int a, input int b,
                                output int r, output int c, output int e, output int lat);
    int k;
    k   = (b > 8) ? 8 : b;
    r   = 0;
    c   = 0;
    e   = 0;
    lat = 1;
    case (op)
      3'd0: begin r = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
      3'd1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin
        r = (a << k) % 256;
        if (k > 0) begin c = (a >> (8 - k)) & 1; lat = k + 1; end
      end
      3'd5: begin
        r = a >> k;
        if (k > 0) begin c = (a >> (k - 1)) & 1; lat = k + 1; end
      end
      default: e = 1;
    endcase
  endfunction

  // Issue one request, time the response, check it, stall it, then consume it.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int stall, input string tag,
                        output logic [7:0] r_obs, output logic c_obs);
    int er, ec, ee, elat, lat;
    model(op, int'(a), int'(b), er, ec, ee, elat);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.opcode    = op;
    bus.in1       = a;
    bus.in2       = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.opcode    = 3'($urandom);
    bus.in1       = 8'($urandom);
    bus.in2       = 8'($urandom);
    check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.rsp_valid && lat < 40);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_carry"}, 32'(bus.carry), 32'(ec));
    check({tag, "_zero"}, 32'(bus.zero), (er == 0) ? 32'd1 : 32'd0);
    check({tag, "_neg"}, 32'(bus.neg), 32'((er >> 7) & 1));
    check({tag, "_err"}, 32'(bus.err), 32'(ee));
    r_obs = bus.result;
    c_obs = bus.carry;
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = 1'b1;
      bus.opcode    = OP_ADD;
      bus.in1       = 8'($urandom);
      bus.in2       = 8'($urandom);
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_stall_result"}, 32'(bus.result), 32'(er));
      check({tag, "_stall_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_consumed"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       c;
    int         seen;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.opcode    = '0;
    bus.in1       = '0;
    bus.in2       = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", {28'd0, bus.carry, bus.zero, bus.neg, bus.err}, 32'd0);

    run_op(OP_ADD, 8'd5, 8'd2, 0, "add_5_2", r, c);
    check("add_5_2_lit", 32'(r), 32'd7);
    run_op(OP_SUB, 8'd2, 8'd5, 0, "sub_2_5", r, c);
    check("sub_2_5_lit", 32'(r), 32'd253);
    run_op(OP_ADD, 8'd200, 8'd100, 0, "add_200_100", r, c);
    check("add_200_100_lit", {23'd0, c, r}, {23'd0, 1'b1, 8'd44});
    run_op(OP_LS, 8'h81, 8'd3, 0, "ls_81_3", r, c);
    check("ls_81_3_lit", 32'(r), 32'h08);
    run_op(OP_RS, 8'hF0, 8'd9, 0, "rs_f0_9", r, c);
    check("rs_f0_9_lit", 32'(r), 32'h00);
    run_op(OP_LS, 8'hA5, 8'd0, 0, "ls_count0", r, c);
    run_op(OP_LS, 8'h01, 8'd200, 0, "ls_clamp", r, c);
    run_op(OP_OR, 8'h0F, 8'hF0, 3, "or_bp", r, c);
    check("or_bp_lit", 32'(r), 32'hFF);

    // Abort a shift with reset in its second cycle.
    bus.req_valid = 1'b1;
    bus.opcode    = OP_LS;
    bus.in1       = 8'h55;
    bus.in2       = 8'd6;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flags", {28'd0, bus.carry, bus.zero, bus.neg, bus.err}, 32'd0);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    run_op(OP_AND, 8'h3C, 8'h0F, 0, "and_after_rst", r, c);
    check("and_after_rst_lit", 32'(r), 32'h0C);

    run_op(3'd7, 8'h12, 8'h34, 1, "illegal7", r, c);
    run_op(3'd6, 8'hFF, 8'h01, 0, "illegal6", r, c);
    run_op(OP_ADD, 8'd1, 8'd1, 0, "err_clear", r, c);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      run_op(op, a, b, $urandom_range(0, 2), $sformatf("rnd%0d", i), r, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
